// File: rtl/param_updown_counter_if.sv
// Control/status bundle of the up/down counter: the master drives the
// count controls and load value, the slave (the counter) returns Q, tc and ovf.
interface param_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             sat_mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             ovf_clr;
  logic [WIDTH-1:0] Q;
  logic             tc;
  logic             ovf;

  modport master (
    output en, up_dn, sat_mode, load, load_val, ovf_clr,
    input  Q, tc, ovf
  );

  modport slave (
    input  en, up_dn, sat_mode, load, load_val, ovf_clr,
    output Q, tc, ovf
  );
endinterface

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with prescaler, parallel load, wrap/saturate
// modes, a registered terminal-count pulse and a sticky overflow flag.
module param_updown_counter #(
  parameter int          WIDTH    = 4,
  parameter int unsigned MAX_VAL  = 15,
  parameter int unsigned PRESCALE = 1
) (
  input logic                   CLK,
  input logic                   reset,
  param_updown_counter_if.slave bus
);
  localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_Q    = WIDTH'(MAX_VAL);
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

  logic [WIDTH-1:0] q;
  logic [PSC_W-1:0] psc;
  logic             tc_r;
  logic             ovf_r;
  logic             step;
  logic             boundary;
  logic [WIDTH-1:0] clipped;

  always_comb begin
    step     = bus.en && (psc == PSC_LAST);
    boundary = step && (bus.up_dn ? (q == MAX_Q) : (q == '0));
    clipped  = (bus.load_val > MAX_Q) ? MAX_Q : bus.load_val;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      q     <= '0;
      psc   <= '0;
      tc_r  <= 1'b0;
      ovf_r <= 1'b0;
    end else if (bus.load) begin
      // Load restarts the prescale period and never raises tc or ovf.
      q    <= clipped;
      psc  <= '0;
      tc_r <= 1'b0;
    end else begin
      tc_r <= boundary;
      if (bus.en) begin
        psc <= step ? '0 : psc + PSC_W'(1);
      end
      if (step) begin
        if (boundary) begin
          if (!bus.sat_mode) begin
            q <= bus.up_dn ? '0 : MAX_Q;
          end
        end else begin
          q <= bus.up_dn ? q + WIDTH'(1) : q - WIDTH'(1);
        end
      end
      // A boundary event in the same cycle as ovf_clr keeps the flag set.
      if (boundary) begin
        ovf_r <= 1'b1;
      end else if (bus.ovf_clr) begin
        ovf_r <= 1'b0;
      end
    end
  end

  assign bus.Q   = q;
  assign bus.tc  = tc_r;
  assign bus.ovf = ovf_r;
endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
Parametrised up/down counter: the next generation of the lab's fixed 4-bit free-running counter. It adds programmable width and modulus, an enable, a clock prescaler, and a direction control. It also adds a synchronous parallel load, wrap/saturate modes, a terminal-count pulse and a sticky overflow flag. It is used standalone in labs and as a timebase/event counter in later blocks.

Parameters:
WIDTH, 4, counter width in bits; legal range 1..32.
MAX_VAL, 15, highest count value, so the modulus is MAX_VAL+1; legal range 1..2^WIDTH-1.
PRESCALE, 1, number of enabled cycles per count step; legal range 1..65535. A value of 1 means the counter steps on every enabled cycle.

Ports:
CLK  input  1  single clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
en  input  1  count enable; gates the prescaler.
up_dn  input  1  1 = count up, 0 = count down; sampled only on step cycles.
sat_mode  input  1  0 = wrap at boundaries, 1 = saturate at boundaries.
load  input  1  synchronous parallel load strobe.
load_val  input  WIDTH  value to load.
ovf_clr  input  1  clears the sticky overflow flag.
Q  output  WIDTH  current count (registered).
tc  output  1  terminal-count pulse (registered, one cycle wide).
ovf  output  1  sticky overflow/underflow flag (registered).

Behaviour:
- Priority on each rising edge: reset > load > count step > hold.
- Reset (sampled at the edge):
  - Q=0, tc=0, ovf=0, internal prescale counter psc=0.
  - Reset asserted mid-prescale or mid-count discards all progress.
- Load:
  - Q <= min(load_val, MAX_VAL); psc <= 0; tc <= 0; ovf unchanged.
  - Load overrides en in the same cycle. Load never generates tc or ovf.
- Prescaler (psc, width ceil(log2(PRESCALE)), minimum 1 bit):
  - When en=1 and not loading: if psc==PRESCALE-1 then step=1 and psc<=0; otherwise psc<=psc+1.
  - When en=0: psc holds and step=0.
  - PRESCALE=1 gives step = en every cycle.
- Count step (step=1):
  - up_dn=1, Q<MAX_VAL: Q<=Q+1.
  - up_dn=1, Q==MAX_VAL: boundary event. Q<=0 if sat_mode=0; Q holds at MAX_VAL if sat_mode=1.
  - up_dn=0, Q>0: Q<=Q-1.
  - up_dn=0, Q==0: boundary event. Q<=MAX_VAL if sat_mode=0; Q holds at 0 if sat_mode=1.
  - If a load_val above MAX_VAL is clipped on load, the clipped Q is treated as MAX_VAL.
- tc:
  - tc<=1 on the edge where a boundary event occurs, so it is visible for exactly the following cycle; otherwise tc<=0.
  - In saturate mode, tc pulses on every attempted step past the boundary (repeat pulses while held).
- ovf:
  - Set on any boundary event.
  - Cleared by ovf_clr.
  - If a boundary event and ovf_clr occur in the same cycle, set wins (ovf=1).
- Direction and mode changes:
  - up_dn and sat_mode may change on any cycle; they take effect on the next step only.
  - No glitch and no extra step results from a change.
- Latency: Q reflects a step, load or reset one clock after the qualifying edge inputs.
- Defaults (WIDTH=4, MAX_VAL=15, PRESCALE=1, en=1, up_dn=1, sat_mode=0) behave as a free-running 4-bit up counter with synchronous reset.

Test Plan:
1. Defaults, reset held 2 cycles then en=1, up_dn=1 for 20 cycles -> Q=0..15,0,1,2,3. tc high exactly the cycle Q returns to 0. ovf=1 from that cycle on.
2. MAX_VAL=9, up_dn=0, load=1 with load_val=2, then 4 step cycles -> Q=2,1,0,9,8. tc pulses once, when Q becomes 9.
3. MAX_VAL=9, sat_mode=1, load_val=12 -> Q=9 (clipped). Then 3 up cycles -> Q stays 9, tc pulses 3 times. Then up_dn=0 -> Q=8.
4. PRESCALE=3, en=1 for 9 cycles with en=0 for 2 cycles inserted after cycle 4 -> Q increments only on enabled cycles 3, 6, 9. psc holds during en=0.
5. Boundary event and ovf_clr=1 in the same cycle -> ovf stays 1. Next cycle ovf_clr=1 with no event -> ovf=0.
6. reset asserted in the same cycle as load=1 and a step -> Q=0, tc=0, ovf=0, psc=0. Counting resumes from 0 the cycle after reset drops.
